vga_fb_dbuf: RTL
================

# vga_fb_dbuf

Parametrised, double-buffered successor to the PPU framebuffer. The PPU writes 6-bit NES colour codes into a back buffer while the VGA pixel pipeline reads the front buffer through the NES palette. A buffer swap is requested by the PPU and committed only during vertical blanking. A hardware clear engine fills the back buffer with one code. The block sits between the PPU pixel output and the VGA timing/DAC stage.

## Interface
Parameters:
- `H_RES`, 256: visible width in pixels.
- `V_RES`, 240: visible height in lines.
- `CODE_W`, 6: colour-code width. The palette has 2^CODE_W entries.
- `CH_W`, 3: bits per RGB channel. `rgb` is 3*CH_W bits.
- `X_W` / `Y_W`: derived, `$clog2(H_RES)` / `$clog2(V_RES)`.

Ports:
- `pix_clk` in 1: the single clock. All logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_cs` in 1: write strobe.
- `wr_x` in X_W, `wr_y` in Y_W: write coordinate.
- `wr_code` in CODE_W: code to store.
- `clr_req` in 1: start clear. Sampled while idle.
- `clr_code` in CODE_W: fill value. Captured with `clr_req`.
- `swap_req` in 1: request a buffer swap.
- `vblank` in 1: vertical blank from VGA timing.
- `busy` out 1: high while a clear is running or a swap is pending.
- `swap_done` out 1: one-cycle pulse on the swap commit cycle.
- `front_sel` out 1: index of the buffer currently displayed.
- `rd_en` in 1: read request.
- `rd_x` in X_W, `rd_y` in Y_W: read coordinate.
- `rgb` out 3*CH_W: {R,G,B} pixel.
- `rgb_valid` out 1: `rgb` is valid.

## Operation
- Storage: two buffers of H_RES*V_RES words, CODE_W bits each. Address = y*H_RES + x.
- Writes go to buffer `~front_sel`. Reads come from buffer `front_sel`.
- Write rejection: a write is ignored if `wr_x >= H_RES`, `wr_y >= V_RES`, or the FSM is in CLEAR.
- Out-of-range reads return the palette entry for code 6'h0F (black).
- Palette: fixed NES table with 3 bits per channel.
  - If CH_W > 3, each channel is MSB-replicated to CH_W bits.
  - If CH_W < 3, each channel is truncated to its upper CH_W bits.
- FSM states: IDLE, CLEAR, SWAP_WAIT.
- IDLE:
  - `clr_req` goes to CLEAR. The clear address counter is zeroed and `clr_code` is latched.
  - Otherwise, `swap_req` or `swap_pend` goes to SWAP_WAIT.
- CLEAR: writes the latched code to one back-buffer address per cycle, incrementing the counter.
  - After address H_RES*V_RES-1, go to SWAP_WAIT if `swap_pend`, else IDLE.
  - `clr_req` is ignored while in CLEAR.
- SWAP_WAIT: on the first cycle with `vblank`=1, toggle `front_sel`, pulse `swap_done`, clear `swap_pend`, go to IDLE.
- `swap_pend`: set by `swap_req` in any state other than SWAP_WAIT.
- Simultaneous `clr_req` and `swap_req` in IDLE: the clear wins, the swap is latched pending, and the swap follows the clear.
- `busy` = (state != IDLE) || `swap_pend`.
- Reset values:
  - state=IDLE, `front_sel`=0, `swap_pend`=0, `busy`=0, `swap_done`=0.
  - `rgb`=0, `rgb_valid`=0, clear counter=0.
  - Buffer contents are not reset.
- Reset mid-clear aborts immediately. Partially cleared contents are left as written.

## Timing
- Write: committed at the `pix_clk` edge where `wr_cs`=1. A read of the same address after a later swap sees it.
- Read latency is 2 cycles.
  - Edge 1 registers the RAM word.
  - Edge 2 registers the palette output into `rgb`.
  - `rgb_valid` follows `rd_en` delayed by 2.
  - Full throughput: one read per cycle.
- When `rd_en`=0, `rgb` holds its last value.
- Swap-cycle ordering: a write or read in the same cycle as the swap commit uses the pre-swap `front_sel`. The new `front_sel` takes effect on the next cycle.
- Clear duration: exactly H_RES*V_RES cycles. `busy` rises the cycle after `clr_req`.
- Swap commit: the earliest commit is the first edge after `swap_req` at which `vblank` is high and no clear is running.

## Structure
- Package `vga_fb_pkg` holds:
  - the 64-entry 9-bit NES palette constant and the `fb_state_t` enum;
  - a function `pal_expand` for channel width scaling.
- Sub-module `fb_dpram`: one simple dual-port RAM with a registered read. It is instantiated twice, once per buffer; the read mux is selected by `front_sel` delayed one cycle.
- The top level holds the FSM, the clear counter, address computation and the palette stage.

## Test plan
All scenarios use H_RES=12, V_RES=6, CH_W=3.
1. Write code 6'h03 at (0,0). Swap with `vblank`=1. Read (0,0) → `rgb`=9'h084, `rgb_valid` two cycles after `rd_en`.
2. Fill every pixel with i+6*j. Swap. Read a full raster → each pixel matches the palette entry for its code, back to back with no gaps.
3. Swap with `vblank`=0 for 10 cycles → `busy`=1, `front_sel` unchanged. Raise `vblank` → single `swap_done` pulse and `front_sel` toggles.
4. Assert `clr_req` (code 6'h21) and `swap_req` in the same cycle, with `vblank` held high:
   - `busy` lasts 72 cycles plus the swap cycle.
   - Writes during the clear are dropped.
   - All reads afterwards return the palette entry for 6'h21.
5. Read (12,0) and (0,6) → black (code 6'h0F). A write to (12,0) leaves the buffer unchanged.
6. Assert `rst` at clear cycle 30 → all outputs at reset values, state IDLE. A new clear then completes normally.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: NES palette, FSM state type and channel-width scaling for vga_fb_dbuf.
package vga_fb_pkg;

    typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} fb_state_t;

    localparam logic [8:0] NES_PAL [64] = '{
        9'o333, 9'o104, 9'o005, 9'o204, 9'o403, 9'o500, 9'o500, 9'o300,
        9'o210, 9'o020, 9'o020, 9'o010, 9'o012, 9'o000, 9'o000, 9'o000,
        9'o555, 9'o037, 9'o117, 9'o407, 9'o505, 9'o702, 9'o610, 9'o620,
        9'o430, 9'o040, 9'o050, 9'o041, 9'o044, 9'o000, 9'o000, 9'o000,
        9'o777, 9'o157, 9'o247, 9'o547, 9'o737, 9'o735, 9'o733, 9'o741,
        9'o751, 9'o460, 9'o262, 9'o274, 9'o076, 9'o000, 9'o000, 9'o000,
        9'o777, 9'o577, 9'o667, 9'o667, 9'o767, 9'o766, 9'o755, 9'o765,
        9'o775, 9'o775, 9'o575, 9'o576, 9'o477, 9'o000, 9'o000, 9'o000
    };

    // Result is right-aligned in w bits: truncation keeps upper bits, widening repeats from the MSB.
    function automatic logic [15:0] pal_expand(input logic [2:0] c, input int w);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < w; i++)
            r[4'(w - 1 - i)] = c[2'(2 - i % 3)];
        return r;
    endfunction

endpackage

// File: rtl/fb_dpram.sv
// fb_dpram: simple dual-port RAM, one write port and one registered read port.
module fb_dpram #(
    parameter int DEPTH = 64,
    parameter int A_W   = 6,
    parameter int D_W   = 6
) (
    input  logic           clk,
    input  logic           we,
    input  logic [A_W-1:0] wa,
    input  logic [D_W-1:0] wd,
    input  logic [A_W-1:0] ra,
    output logic [D_W-1:0] rd
);

    logic [D_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[wa] <= wd;
        rd <= mem[ra];
    end

endmodule

// File: rtl/vga_fb_dbuf.sv
// vga_fb_dbuf: double-buffered NES-code framebuffer with vblank-gated swap,
// hardware clear engine and a two-stage palette read pipeline.
module vga_fb_dbuf
    import vga_fb_pkg::*;
#(
    parameter int H_RES  = 256,
    parameter int V_RES  = 240,
    parameter int CODE_W = 6,
    parameter int CH_W   = 3,
    parameter int X_W    = $clog2(H_RES),
    parameter int Y_W    = $clog2(V_RES)
) (
    input  logic              pix_clk,
    input  logic              rst,
    input  logic              wr_cs,
    input  logic [X_W-1:0]    wr_x,
    input  logic [Y_W-1:0]    wr_y,
    input  logic [CODE_W-1:0] wr_code,
    input  logic              clr_req,
    input  logic [CODE_W-1:0] clr_code,
    input  logic              swap_req,
    input  logic              vblank,
    output logic              busy,
    output logic              swap_done,
    output logic              front_sel,
    input  logic              rd_en,
    input  logic [X_W-1:0]    rd_x,
    input  logic [Y_W-1:0]    rd_y,
    output logic [3*CH_W-1:0] rgb,
    output logic              rgb_valid
);

    localparam int N   = H_RES * V_RES;
    localparam int A_W = $clog2(N);
    localparam logic [A_W-1:0]    LAST  = A_W'(N - 1);
    localparam logic [X_W:0]      X_LIM = (X_W + 1)'(H_RES);
    localparam logic [Y_W:0]      Y_LIM = (Y_W + 1)'(V_RES);
    localparam logic [CODE_W-1:0] BLACK = CODE_W'(15);

    fb_state_t         state, state_n;
    logic              swap_pend, pend_n, front_n, clr_start;
    logic [A_W-1:0]    clr_cnt;
    logic [CODE_W-1:0] clr_val;
    logic              wr_in, rd_in, ram_we;
    logic [A_W-1:0]    wr_addr, rd_addr, ram_wa;
    logic [CODE_W-1:0] ram_wd, code_sel;
    logic [CODE_W-1:0] rd_word [2];
    logic              sel_d, oor_d, en_d;
    logic [8:0]        pal_w;
    logic [3*CH_W-1:0] rgb_n;

    assign wr_in   = ({1'b0, wr_x} < X_LIM) && ({1'b0, wr_y} < Y_LIM);
    assign rd_in   = ({1'b0, rd_x} < X_LIM) && ({1'b0, rd_y} < Y_LIM);
    assign wr_addr = A_W'(wr_y) * A_W'(H_RES) + A_W'(wr_x);
    assign rd_addr = rd_in ? A_W'(rd_y) * A_W'(H_RES) + A_W'(rd_x) : '0;
    assign ram_we  = (state == CLEAR) || (wr_cs && wr_in);
    assign ram_wa  = (state == CLEAR) ? clr_cnt : wr_addr;
    assign ram_wd  = (state == CLEAR) ? clr_val : wr_code;
    assign busy    = (state != IDLE) || swap_pend;

    always_comb begin
        state_n   = state;
        front_n   = front_sel;
        pend_n    = swap_pend || (swap_req && state != SWAP_WAIT);
        clr_start = 1'b0;
        swap_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (clr_req) begin
                    state_n   = CLEAR;
                    clr_start = 1'b1;
                end else if (pend_n) begin
                    state_n = SWAP_WAIT;
                end
            end
            CLEAR: begin
                if (clr_cnt == LAST)
                    state_n = pend_n ? SWAP_WAIT : IDLE;
            end
            SWAP_WAIT: begin
                if (vblank) begin
                    state_n   = IDLE;
                    front_n   = ~front_sel;
                    pend_n    = 1'b0;
                    swap_done = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            state     <= IDLE;
            front_sel <= 1'b0;
            swap_pend <= 1'b0;
            clr_cnt   <= '0;
        end else begin
            state     <= state_n;
            front_sel <= front_n;
            swap_pend <= pend_n;
            if (clr_start) begin
                clr_cnt <= '0;
                clr_val <= clr_code;
            end else if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_buf
        fb_dpram #(.DEPTH(N), .A_W(A_W), .D_W(CODE_W)) u_ram (
            .clk (pix_clk),
            .we  (ram_we && (front_sel != 1'(b))),
            .wa  (ram_wa),
            .wd  (ram_wd),
            .ra  (rd_addr),
            .rd  (rd_word[b])
        );
    end

    assign code_sel = oor_d ? BLACK : rd_word[sel_d];
    assign pal_w    = NES_PAL[code_sel];
    assign rgb_n    = {CH_W'(pal_expand(pal_w[8:6], CH_W)),
                       CH_W'(pal_expand(pal_w[5:3], CH_W)),
                       CH_W'(pal_expand(pal_w[2:0], CH_W))};

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            sel_d     <= 1'b0;
            oor_d     <= 1'b0;
            en_d      <= 1'b0;
            rgb       <= '0;
            rgb_valid <= 1'b0;
        end else begin
            sel_d     <= front_sel;
            oor_d     <= !rd_in;
            en_d      <= rd_en;
            rgb_valid <= en_d;
            if (en_d)
                rgb <= rgb_n;
        end
    end

endmodule
